bus_rr_arbiter: RTL and testbench
=================================

// Module: bus_rr_arbiter
// PURPOSE
//  Shares the single 16-bit source bus (selected by bus read_en) between N_REQ core controllers.
//  Each requester asks for tenure and presents its desired 5-bit source code.
//  The arbiter grants round-robin, enforces a maximum tenure when others wait, and drives the
//  registered read_en into the bus mux. Sits between the per-core control units and the bus.
// PARAMETERS
//  N_REQ     4   number of requesters (2..8)
//  SEL_W     5   width of read_en / source code
//  MAX_HOLD  8   tenure cycles after which owner is pre-empted if another req is pending (>=2)
// PORTS
//  clk       in   1             system clock, all state on rising edge
//  rst       in   1             synchronous reset, active-high
//  req       in   N_REQ         level request per requester; hold high for whole tenure
//  sel_in    in   N_REQ*SEL_W   source code per requester, requester i at [i*SEL_W +: SEL_W]
//  grant     out  N_REQ         one-hot grant (registered), all-zero when idle
//  owner     out  3             index of current owner (valid when busy)
//  busy      out  1             1 while a grant is active
//  read_en   out  SEL_W         registered source select to bus; 0 = no source
//  preempt   out  1             1-cycle pulse on the cycle a forced rotation takes effect
// BEHAVIOUR
//  Reset: grant=0, owner=0, busy=0, read_en=0, preempt=0, rr pointer=0, hold_cnt=0, state IDLE.
//  Reset mid-tenure aborts it; all outputs reach reset values on the edge where rst=1.
//  States: IDLE, OWN.
//  Arbitration pick: first i with req[i]=1 searching ptr, ptr+1, ... wrapping mod N_REQ.
//  IDLE: if any req at edge -> OWN; grant/owner = pick; read_en = sel_in[pick] sampled same edge;
//    hold_cnt=1; ptr = pick+1 (mod N_REQ). Latency req->grant = 1 cycle. No req -> stay IDLE.
//  OWN, each edge, evaluated in priority order:
//   1. req[owner]=0 (release): if other req pending -> direct hand-off to pick (no idle bubble),
//      same update as IDLE grant; else -> IDLE, grant=0, busy=0, read_en=0.
//   2. hold_cnt>=MAX_HOLD and another requester pending -> forced hand-off to pick (owner excluded),
//      preempt=1 for that cycle. Preempted requester keeps req high and re-queues in rr order.
//   3. otherwise stay; read_en <= sel_in[owner] (owner may change source, 1-cycle latency);
//      hold_cnt increments, saturating at MAX_HOLD (no rotation while alone).
//  read_en only ever carries the current owner's code; changes to non-owner sel_in are ignored.
//  Pick never selects a requester with req=0; grant is always one-hot or zero.
//  Simultaneous release by owner and new req from same index on same edge: treated as release;
//    that index is lowest priority in the search (ptr already past it).
//  sel_in codes are passed through unchecked; code 0 from owner drives an empty bus.
//  busy = |grant; owner holds last value when idle.
// TESTING
//  1. rst=1 2 cycles with req=4'b1111 -> grant=0, read_en=0, busy=0 throughout; after release,
//     first grant is requester 0.
//  2. req=4'b0100, sel_in[2]=4 (ra) -> next cycle grant=4'b0100, owner=2, read_en=4; change
//     sel_in[2] to 11 -> read_en=11 one cycle later; drop req -> IDLE, read_en=0 next cycle.
//  3. req=4'b1111 from IDLE, each owner drops req after 3 cycles -> grant order 0,1,2,3,
//     back-to-back hand-offs with no zero-grant cycle between them.
//  4. req0 held forever, req1 raised 2 cycles after grant0 (MAX_HOLD=8) -> grant moves to 1
//     after 8th cycle of tenure with preempt pulse; on req1 release grant returns to 0.
//  5. req0 alone held 20 cycles -> grant stays 0, no preempt, read_en tracks sel_in[0].
//  6. rst asserted mid-tenure of requester 3 -> next edge all outputs reset; release with req3
//     still high -> grant returns to 3 one cycle later (ptr reset to 0, only 3 requesting).

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin owner of the shared source bus with max-tenure pre-emption
module bus_rr_arbiter #(
   parameter int N_REQ    = 4,
   parameter int SEL_W    = 5,
   parameter int MAX_HOLD = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*SEL_W-1:0] sel_in,
   output logic [N_REQ-1:0]       grant,
   output logic [2:0]             owner,
   output logic                   busy,
   output logic [SEL_W-1:0]       read_en,
   output logic                   preempt
);
   localparam int HW = $clog2(MAX_HOLD + 1);
   typedef enum logic {IDLE, OWN} state_t;
   state_t            state_q, state_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [2:0]        owner_q, owner_d, ptr_q, ptr_d, pick, idx;
   logic [SEL_W-1:0]  read_en_q, read_en_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic              preempt_q, preempt_d, found, rel, give;
   logic [7:0]        req8, cand;
   logic [SEL_W-1:0]  sel_a [8];
   for (genvar g = 0; g < 8; g++) begin : g_sel
      if (g < N_REQ) begin : g_on
         assign sel_a[g] = sel_in[g*SEL_W +: SEL_W];
      end else begin : g_off
         assign sel_a[g] = '0;
      end
   end
   // the current owner never competes in its own hand-off search
   always_comb begin
      req8  = 8'(req);
      cand  = state_q == OWN ? req8 & ~8'(grant_q) : req8;
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = 3'((32'(ptr_q) + k) % N_REQ);
         if (!found && cand[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         read_en_q <= '0;
         hold_q    <= '0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         read_en_q <= read_en_d;
         hold_q    <= hold_d;
         preempt_q <= preempt_d;
      end
   end
   always_comb begin
      rel       = state_q == OWN && !req8[owner_q];
      give      = found && (state_q == IDLE || rel || hold_q >= HW'(MAX_HOLD));
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      read_en_d = read_en_q;
      hold_d    = hold_q;
      preempt_d = 1'b0;
      if (give) begin
         state_d   = OWN;
         grant_d   = N_REQ'(8'd1 << pick);
         owner_d   = pick;
         ptr_d     = 3'((32'(pick) + 1) % N_REQ);
         read_en_d = sel_a[pick];
         hold_d    = HW'(1);
         preempt_d = state_q == OWN && !rel;
      end else if (rel) begin
         state_d   = IDLE;
         grant_d   = '0;
         read_en_d = '0;
         hold_d    = '0;
      end else if (state_q == OWN) begin
         read_en_d = sel_a[owner_q];
         hold_d    = hold_q >= HW'(MAX_HOLD) ? hold_q : hold_q + 1'b1;
      end
   end
   always_comb begin
      grant   = grant_q;
      owner   = owner_q;
      busy    = |grant_q;
      read_en = read_en_q;
      preempt = preempt_q;
   end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed and random checks of bus_rr_arbiter against a tenure-level model
module tb_bus_rr_arbiter;
   localparam int N = 4, SW = 5, MAXH = 8;
   logic          clk = 0, rst = 1;
   logic [N-1:0]  req = '0;
   logic [N*SW-1:0] sel_in = '0;
   logic [N-1:0]  grant;
   logic [2:0]    owner;
   logic          busy, preempt;
   logic [SW-1:0] read_en;
   int n_cmp = 0, n_bad = 0;

   bus_rr_arbiter #(.N_REQ(N), .SEL_W(SW), .MAX_HOLD(MAXH)) dut (
      .clk(clk), .rst(rst), .req(req), .sel_in(sel_in), .grant(grant),
      .owner(owner), .busy(busy), .read_en(read_en), .preempt(preempt));

   always #5 clk = ~clk;

   function void chk(string n, logic [31:0] a, logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endfunction

   function logic [SW-1:0] selof(int i);
      return sel_in[i*SW +: SW];
   endfunction

   task cyc();
      @(posedge clk);
      #2;
   endtask

   task setsel(int i, logic [SW-1:0] v);
      sel_in[i*SW +: SW] = v;
   endtask

   // tenure-level model: who owns the bus, for how long, and where the search starts
   bit            m_busy = 0, m_pre = 0;
   int            m_own = 0, m_ptr = 0, m_ten = 0;
   logic [SW-1:0] m_rd = '0;
   always @(posedge clk) begin
      int p, c;
      bit f;
      if (rst) begin
         m_busy = 0; m_own = 0; m_ptr = 0; m_ten = 0; m_rd = '0; m_pre = 0;
      end else begin
         f = 0; p = 0;
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (!f && req[c] && !(m_busy && c == m_own)) begin f = 1; p = c; end
         end
         m_pre = 0;
         if (m_busy && req[m_own] && !(f && m_ten >= MAXH)) begin
            m_ten++;
            m_rd = selof(m_own);
         end else if (f) begin
            m_pre = m_busy && req[m_own];
            m_busy = 1; m_own = p; m_ten = 1; m_ptr = (p + 1) % N; m_rd = selof(p);
         end else begin
            m_busy = 0; m_rd = '0;
         end
      end
   end

   always @(negedge clk) begin
      chk("grant", 32'(grant), m_busy ? 32'(1) << m_own : 32'd0);
      chk("owner", 32'(owner), 32'(m_own));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("read_en", 32'(read_en), 32'(m_rd));
      chk("preempt", 32'(preempt), 32'(m_pre));
   end

   initial begin
      logic [SW-1:0] prev;
      // reset holds everything off even with all requesting
      rst = 1; req = 4'b1111;
      cyc(); chk("t1_grant", 32'(grant), 0); chk("t1_rd", 32'(read_en), 0); chk("t1_busy", 32'(busy), 0);
      cyc(); chk("t1_grant2", 32'(grant), 0); chk("t1_busy2", 32'(busy), 0);
      rst = 0;
      cyc(); chk("t1_first", 32'(grant), 32'b0001); chk("t1_owner", 32'(owner), 0);
      req = '0;
      cyc(); chk("t1_idle", 32'(busy), 0);
      // single requester, source change, release
      req = 4'b0100; setsel(2, 5'd4);
      cyc(); chk("t2_grant", 32'(grant), 32'b0100); chk("t2_owner", 32'(owner), 2); chk("t2_rd", 32'(read_en), 4);
      setsel(2, 5'd11);
      cyc(); chk("t2_rd11", 32'(read_en), 11);
      req = '0;
      cyc(); chk("t2_rd0", 32'(read_en), 0); chk("t2_grant0", 32'(grant), 0);
      // back-to-back rotation 0,1,2,3
      rst = 1; cyc(); rst = 0;
      req = 4'b1111;
      cyc();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < 3; j++) begin
            chk("t3_order", 32'(grant), 32'(1) << i);
            if (j == 2) req[i] = 1'b0;
            cyc();
         end
      chk("t3_done", 32'(busy), 0);
      // pre-emption after MAX_HOLD cycles of tenure
      rst = 1; cyc(); rst = 0;
      req = 4'b0001;
      cyc(); cyc(); cyc();
      req = 4'b0011;
      for (int j = 3; j < MAXH; j++) begin
         chk("t4_hold", 32'(grant), 32'b0001); chk("t4_nopre", 32'(preempt), 0);
         cyc();
      end
      chk("t4_hold8", 32'(grant), 32'b0001);
      cyc(); chk("t4_pre_grant", 32'(grant), 32'b0010); chk("t4_pre", 32'(preempt), 1);
      cyc(); chk("t4_pre_off", 32'(preempt), 0);
      req = 4'b0001;
      cyc(); chk("t4_back", 32'(grant), 32'b0001); chk("t4_back_pre", 32'(preempt), 0);
      // lone requester is never rotated, source tracked
      rst = 1; cyc(); rst = 0;
      req = 4'b0001;
      for (int j = 0; j < 20; j++) begin
         prev = 5'($urandom);
         setsel(0, prev);
         cyc();
         chk("t5_grant", 32'(grant), 32'b0001); chk("t5_pre", 32'(preempt), 0);
         chk("t5_rd", 32'(read_en), 32'(prev));
      end
      // reset mid-tenure aborts, pointer restarts
      rst = 1; cyc(); rst = 0;
      req = 4'b1000; setsel(3, 5'd17);
      cyc(); chk("t6_grant", 32'(grant), 32'b1000); chk("t6_owner", 32'(owner), 3);
      cyc(); rst = 1;
      cyc(); chk("t6_rst_g", 32'(grant), 0); chk("t6_rst_o", 32'(owner), 0); chk("t6_rst_rd", 32'(read_en), 0);
      chk("t6_rst_b", 32'(busy), 0); chk("t6_rst_p", 32'(preempt), 0);
      rst = 0;
      cyc(); chk("t6_regrant", 32'(grant), 32'b1000); chk("t6_rd", 32'(read_en), 17);
      // random traffic checked by the model every cycle
      for (int t = 0; t < 3000; t++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(5) == 0) req[i] = ~req[i];
            if ($urandom_range(3) == 0) setsel(i, 5'($urandom));
         end
         rst = $urandom_range(199) == 0;
         cyc();
      end
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
